forward_hazard_unit: RTL and testbench

Parametrised, stateful forwarding and load-use hazard unit for the five-stage MIPS pipeline. It tracks every in-flight register write in an internal shift table, produces registered per-port forwarding selects for the instruction entering EX, and raises a load-use stall in ID. It replaces the fixed two-port, two-source combinational comparator. It sits beside the ID/EX pipeline register and is driven by the decode stage.

---
 rtl/fwd_pkg.sv | 14 +
 rtl/fwd_port_match.sv | 27 ++
 rtl/forward_hazard_unit.sv | 66 ++++++
 tb/tb_forward_hazard_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and table entry type for the forwarding/hazard unit
package fwd_pkg;
  localparam int SEL_SRC_REGFILE = 0;
  localparam int STAGE_EX = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB = 2;
  localparam int TAG_W = 16;
  localparam int READY_W = 8;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] dest;
    logic [READY_W-1:0] ready;
  } fwd_entry_t;
endpackage

// File: rtl/fwd_port_match.sv
// fwd_port_match: youngest-match search of one source port over the matchable table entries
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int ADDR_W = 5,
  parameter int SEL_W = 2
) (
  input  fwd_entry_t [DEPTH-2:0] tbl,
  input  logic [ADDR_W-1:0]      src,
  input  logic                   used,
  output logic                   match,
  output logic [SEL_W-1:0]       idx,
  output logic [READY_W-1:0]     ready
);
  always_comb begin
    match = 1'b0;
    idx = '0;
    ready = '0;
    for (int j = DEPTH - 2; j >= 0; j--)
      if (used && tbl[j].valid && tbl[j].dest != '0 && tbl[j].dest == TAG_W'(src)) begin
        match = 1'b1;
        idx = SEL_W'(j);
        ready = tbl[j].ready;
      end
  end
endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: in-flight write table driving registered EX forwarding selects and ID load-use stall
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 5,
  parameter int DEPTH = 3,
  parameter int ALU_READY = 1,
  parameter int LOAD_READY = 2,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          ID_Valid,
  input  logic [NUM_PORTS*ADDR_W-1:0]   ID_SrcReg,
  input  logic [NUM_PORTS-1:0]          ID_SrcUsed,
  input  logic [ADDR_W-1:0]             ID_DestReg,
  input  logic                          ID_RegWrite,
  input  logic                          ID_IsLoad,
  input  logic                          Flush,
  input  logic                          Freeze,
  output logic                          Stall,
  output logic [NUM_PORTS*SEL_W-1:0]    EX_FwdSel,
  output logic                          EX_Valid,
  output logic [CNT_W-1:0]              StallCount
);
  fwd_entry_t [DEPTH-1:0] tbl;
  logic [NUM_PORTS-1:0] match;
  logic [NUM_PORTS-1:0] late;
  logic [SEL_W-1:0] idx [NUM_PORTS];
  logic [READY_W-1:0] rdy [NUM_PORTS];
  logic [NUM_PORTS*SEL_W-1:0] next_sel;
  logic issue;
  genvar p;
  for (p = 0; p < NUM_PORTS; p++) begin : g_port
    fwd_port_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_match (
      .tbl(tbl[DEPTH-2:0]),
      .src(ID_SrcReg[p*ADDR_W +: ADDR_W]),
      .used(ID_SrcUsed[p]),
      .match(match[p]),
      .idx(idx[p]),
      .ready(rdy[p])
    );
    assign late[p] = match[p] && (READY_W'(idx[p]) + READY_W'(1) < rdy[p]);
    assign next_sel[p*SEL_W +: SEL_W] = match[p] ? idx[p] + SEL_W'(1) : SEL_W'(SEL_SRC_REGFILE);
  end
  assign Stall = ID_Valid && !Flush && |late;
  assign issue = ID_Valid && !Stall && !Flush;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      tbl <= '0;
      EX_FwdSel <= '0;
      EX_Valid <= 1'b0;
      StallCount <= '0;
    end else if (!Freeze) begin
      tbl <= {tbl[DEPTH-2:0], fwd_entry_t'{
        valid: issue && ID_RegWrite && ID_DestReg != '0,
        dest: TAG_W'(ID_DestReg),
        ready: ID_IsLoad ? READY_W'(LOAD_READY) : READY_W'(ALU_READY)}};
      EX_FwdSel <= issue ? next_sel : '0;
      EX_Valid <= issue;
      StallCount <= StallCount + CNT_W'(Stall && !(&StallCount));
    end
  end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed and random stimulus against an age-history reference model
module tb_forward_hazard_unit;
  localparam int NP = 2;
  localparam int D = 3;
  typedef struct {
    bit wr;
    int dest;
    bit ld;
  } rec_t;
  logic Clk = 1'b0;
  logic Rst_n;
  logic ID_Valid;
  logic [9:0] ID_SrcReg;
  logic [1:0] ID_SrcUsed;
  logic [4:0] ID_DestReg;
  logic ID_RegWrite;
  logic ID_IsLoad;
  logic Flush;
  logic Freeze;
  logic Stall;
  logic [3:0] EX_FwdSel;
  logic EX_Valid;
  logic [15:0] StallCount;
  rec_t hist[D];
  int checks = 0;
  int failures = 0;
  bit exp_v = 0;
  logic [3:0] exp_sel = '0;
  int exp_cnt = 0;
  always #5 Clk = ~Clk;
  forward_hazard_unit dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .ID_Valid(ID_Valid),
    .ID_SrcReg(ID_SrcReg),
    .ID_SrcUsed(ID_SrcUsed),
    .ID_DestReg(ID_DestReg),
    .ID_RegWrite(ID_RegWrite),
    .ID_IsLoad(ID_IsLoad),
    .Flush(Flush),
    .Freeze(Freeze),
    .Stall(Stall),
    .EX_FwdSel(EX_FwdSel),
    .EX_Valid(EX_Valid),
    .StallCount(StallCount)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Youngest earlier instruction (age 1 = just entered EX) that writes r; only ages 1..D-1 forward.
  function automatic void look(input int r, input bit used, output int age, output int need);
    bit found = 0;
    age = 0;
    need = 0;
    if (used && r != 0)
      for (int a = 1; a <= D - 1; a++)
        if (!found && hist[a-1].wr && hist[a-1].dest == r) begin
          found = 1;
          age = a;
          need = hist[a-1].ld ? 2 : 1;
        end
  endfunction
  task automatic step(input bit v, input int s0, input int s1, input bit [1:0] u, input int d,
                      input bit rw, input bit ld, input bit fl, input bit fz, input bit rn);
    int age[NP];
    int need[NP];
    bit st;
    @(negedge Clk);
    Rst_n = rn;
    ID_Valid = v;
    ID_SrcReg = {5'(s1), 5'(s0)};
    ID_SrcUsed = u;
    ID_DestReg = 5'(d);
    ID_RegWrite = rw;
    ID_IsLoad = ld;
    Flush = fl;
    Freeze = fz;
    #1;
    look(s0, u[0], age[0], need[0]);
    look(s1, u[1], age[1], need[1]);
    st = 0;
    for (int p = 0; p < NP; p++)
      if (age[p] != 0 && age[p] < need[p]) st = 1;
    st = v && !fl && st;
    chk("stall", Stall, st);
    @(posedge Clk);
    if (!rn) begin
      for (int i = 0; i < D; i++) hist[i] = '{0, 0, 0};
      exp_v = 0;
      exp_sel = '0;
      exp_cnt = 0;
    end else if (!fz) begin
      for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{v && rw && d != 0 && !st && !fl, d, ld};
      exp_v = v && !st && !fl;
      exp_sel = exp_v ? {2'(age[1]), 2'(age[0])} : 4'b0;
      if (st && exp_cnt != 65535) exp_cnt++;
    end
    #1;
    chk("ex_valid", EX_Valid, exp_v);
    chk("ex_fwdsel", EX_FwdSel, exp_sel);
    chk("stall_count", StallCount, exp_cnt);
  endtask
  initial begin
    for (int i = 0; i < D; i++) hist[i] = '{0, 0, 0};
    Rst_n = 0;
    ID_Valid = 0;
    ID_SrcReg = '0;
    ID_SrcUsed = '0;
    ID_DestReg = '0;
    ID_RegWrite = 0;
    ID_IsLoad = 0;
    Flush = 0;
    Freeze = 0;
    @(posedge Clk);
    step(1, 3, 4, 2'b11, 9, 1, 1, 0, 0, 0);
    chk("rst_valid", EX_Valid, 0);
    chk("rst_sel", EX_FwdSel, 0);
    chk("rst_cnt", StallCount, 0);
    step(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 1);
    step(1, 3, 4, 2'b11, 5, 1, 0, 0, 0, 1);
    chk("alu_sel", EX_FwdSel, 4'b0001);
    chk("alu_valid", EX_Valid, 1);
    step(1, 29, 0, 2'b01, 8, 1, 1, 0, 0, 1);
    step(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 1);
    chk("lu_stall_cnt", StallCount, 1);
    step(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 1);
    chk("lu_sel", EX_FwdSel, 4'b1010);
    step(1, 1, 1, 2'b11, 2, 1, 0, 0, 0, 1);
    step(1, 1, 1, 2'b11, 2, 1, 0, 0, 0, 1);
    step(1, 2, 0, 2'b11, 6, 1, 0, 0, 0, 1);
    chk("young_sel", EX_FwdSel, 4'b0001);
    step(1, 1, 1, 2'b11, 7, 1, 0, 0, 0, 1);
    step(1, 1, 1, 2'b11, 10, 1, 0, 0, 0, 1);
    step(1, 1, 1, 2'b11, 11, 1, 0, 0, 0, 1);
    step(1, 7, 7, 2'b11, 12, 1, 0, 0, 0, 1);
    chk("wfirst_sel", EX_FwdSel, 4'b0000);
    step(1, 1, 1, 2'b11, 8, 1, 1, 0, 0, 1);
    step(1, 8, 1, 2'b11, 9, 1, 0, 1, 0, 1);
    chk("flush_valid", EX_Valid, 0);
    step(1, 1, 1, 2'b11, 8, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8, 1, 2'b11, 9, 1, 0, 0, 1, 1);
    chk("freeze_cnt", StallCount, 1);
    step(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 1);
    chk("unfreeze_cnt", StallCount, 2);
    step(1, 1, 1, 2'b11, 8, 1, 1, 0, 0, 1);
    step(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 0);
    chk("rst_mid_cnt", StallCount, 0);
    step(1, 8, 8, 2'b11, 9, 1, 0, 0, 0, 1);
    chk("rst_mid_sel", EX_FwdSel, 0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
